// File: rtl/csr_exec_unit.sv
// Zicsr execute-stage sequencer: read-modify-write of one CSR per instruction, old value returned for rd.
// Optional performance counters are compiled in with `define CSR_EXEC_PERF_EN.
module csr_exec_unit #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [CSR_AW-1:0] in_csr_addr,
  input  logic [4:0]        in_rs1_idx,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [4:0]        in_rd_idx,
  output logic              csr_rd_ena,
  output logic [CSR_AW-1:0] csr_rd_addr,
  input  logic [XLEN-1:0]   csr_rd_data,
  output logic              csr_wr_ena,
  output logic [CSR_AW-1:0] csr_wr_addr,
  output logic [XLEN-1:0]   csr_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd_idx,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_illegal
`ifdef CSR_EXEC_PERF_EN
  ,
  output logic [XLEN-1:0]   perf_retired,
  output logic [31:0]       perf_illegal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [CSR_AW-1:0]   addr_q, addr_d;
  logic [4:0]          rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]     rs1_data_q, rs1_data_d;
  logic [4:0]          rd_idx_q, rd_idx_d;
  logic [XLEN-1:0]     old_q, old_d;
  logic                illegal_q, illegal_d;

  logic                accept;
  logic                acc_do_write;
  logic                acc_illegal;
  logic                do_write;
  logic                do_read;
  logic [XLEN-1:0]     src;
  logic                handshake;

  // Legality is decided from the raw instruction fields so an illegal op never enters READ.
  assign accept       = in_valid & in_ready;
  assign acc_do_write = (in_funct3[1:0] == 2'b01) | (in_rs1_idx != 5'd0);
  assign acc_illegal  = (in_funct3[1:0] == 2'b00) |
                        (acc_do_write & (in_csr_addr[CSR_AW-1 -: 2] == 2'b11));

  assign do_write  = (funct3_q[1:0] == 2'b01) | (rs1_idx_q != 5'd0);
  assign do_read   = ~((funct3_q[1:0] == 2'b01) & (rd_idx_q == 5'd0));
  assign src       = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
  assign handshake = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      rd_idx_q   <= rd_idx_d;
      old_q      <= old_d;
      illegal_q  <= illegal_d;
    end
  end

  // NOTE: every combinational output gets a default first, which rules out latch inference.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = acc_illegal ? S_RESP : S_READ;
      S_READ:  state_d = do_write ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (handshake) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    rs1_idx_d  = rs1_idx_q;
    rs1_data_d = rs1_data_q;
    rd_idx_d   = rd_idx_q;
    old_d      = old_q;
    illegal_d  = illegal_q;
    if (accept) begin
      funct3_d   = in_funct3;
      addr_d     = in_csr_addr;
      rs1_idx_d  = in_rs1_idx;
      rs1_data_d = in_rs1_data;
      rd_idx_d   = in_rd_idx;
      old_d      = '0;
      illegal_d  = acc_illegal;
    end
    // Old value is sampled only in READ; a skipped read returns zero.
    if (state_q == S_READ) old_d = do_read ? csr_rd_data : '0;
  end

  always_comb begin
    in_ready    = (state_q == S_IDLE) & rst;
    csr_rd_ena  = 1'b0;
    csr_rd_addr = '0;
    csr_wr_ena  = 1'b0;
    csr_wr_addr = '0;
    csr_wr_data = '0;
    out_valid   = 1'b0;
    out_rd_idx  = '0;
    out_rd_wen  = 1'b0;
    out_rd_data = '0;
    out_illegal = 1'b0;
    unique case (state_q)
      S_READ: begin
        csr_rd_ena  = do_read;
        csr_rd_addr = addr_q;
      end
      S_WRITE: begin
        csr_wr_ena  = 1'b1;
        csr_wr_addr = addr_q;
        case (funct3_q[1:0])
          2'b10:   csr_wr_data = old_q | src;
          2'b11:   csr_wr_data = old_q & ~src;
          default: csr_wr_data = src;
        endcase
      end
      S_RESP: begin
        out_valid   = 1'b1;
        out_rd_idx  = rd_idx_q;
        out_rd_wen  = (rd_idx_q != 5'd0) & ~illegal_q;
        out_rd_data = old_q;
        out_illegal = illegal_q;
      end
      default: ;
    endcase
  end

`ifdef CSR_EXEC_PERF_EN
  logic [XLEN-1:0] perf_retired_q, perf_retired_d;
  logic [31:0]     perf_illegal_q, perf_illegal_d;

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_illegal_d = perf_illegal_q;
    if (handshake) begin
      if (illegal_q) perf_illegal_d = perf_illegal_q + 32'd1;
      else           perf_retired_d = perf_retired_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired_q <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: CSR file environment, transaction-level reference model, directed and random stimulus.
// Build with +define+CSR_EXEC_PERF_EN to also check the performance counters.
module tb_csr_exec_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] CNT0 = 64'd1000;
  localparam logic [63:0] INIT_VAL [6] = '{64'h8000000000000100, 64'h0, 64'h0,
                                           64'h00000000000005A5, 64'h0000000000000777,
                                           64'hDEADBEEF00000001};
  localparam logic [11:0] ADDRS [6] = '{12'h301, 12'h340, 12'hB00, 12'hF11, 12'hC00, 12'h7C0};

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [11:0]     in_csr_addr;
  logic [4:0]      in_rs1_idx;
  logic [63:0]     in_rs1_data;
  logic [4:0]      in_rd_idx;
  logic            csr_rd_ena;
  logic [11:0]     csr_rd_addr;
  logic [63:0]     csr_rd_data;
  logic            csr_wr_ena;
  logic [11:0]     csr_wr_addr;
  logic [63:0]     csr_wr_data;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd_idx;
  logic            out_rd_wen;
  logic [63:0]     out_rd_data;
  logic            out_illegal;
`ifdef CSR_EXEC_PERF_EN
  logic [63:0]     perf_retired;
  logic [31:0]     perf_illegal;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_exec_unit #(.XLEN(XLEN), .CSR_AW(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_csr_addr (in_csr_addr),
    .in_rs1_idx  (in_rs1_idx),
    .in_rs1_data (in_rs1_data),
    .in_rd_idx   (in_rd_idx),
    .csr_rd_ena  (csr_rd_ena),
    .csr_rd_addr (csr_rd_addr),
    .csr_rd_data (csr_rd_data),
    .csr_wr_ena  (csr_wr_ena),
    .csr_wr_addr (csr_wr_addr),
    .csr_wr_data (csr_wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd_idx  (out_rd_idx),
    .out_rd_wen  (out_rd_wen),
    .out_rd_data (out_rd_data),
    .out_illegal (out_illegal)
`ifdef CSR_EXEC_PERF_EN
    ,
    .perf_retired(perf_retired),
    .perf_illegal(perf_illegal)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      12'h301: return 0;
      12'h340: return 1;
      12'hB00: return 2;
      12'hF11: return 3;
      12'hC00: return 4;
      12'h7C0: return 5;
      default: return 0;
    endcase
  endfunction

  // ---------------- CSR register file environment (0xB00 is a free-running counter) ----------------
  logic [63:0] env_mem [6];
  logic [63:0] env_cnt;
  int          env_rd_n = 0;
  int          env_wr_n = 0;
  int          edge_n   = 0;

  always_comb csr_rd_data = (csr_rd_addr == 12'hB00) ? env_cnt : env_mem[csr_idx(csr_rd_addr)];

  initial begin
    for (int i = 0; i < 6; i++) env_mem[i] = INIT_VAL[i];
    env_cnt = CNT0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (csr_rd_ena === 1'b1) env_rd_n++;
      if (csr_wr_ena === 1'b1) begin
        env_wr_n++;
        if (csr_wr_addr == 12'hB00) env_cnt <= csr_wr_data;
        else begin
          env_mem[csr_idx(csr_wr_addr)] <= csr_wr_data;
          env_cnt <= env_cnt + 64'd1;
        end
      end else begin
        env_cnt <= env_cnt + 64'd1;
      end
    end
  end

  // ---------------- Transaction-level reference model, checked every cycle at negedge ----------------
  logic [63:0] ref_mem [6];
  logic [63:0] ref_cnt;
  logic [63:0] ref_perf_ret;
  logic [31:0] ref_perf_ill;
  bit          busy;
  int          cyc, t_read_cyc, t_resp_cyc;
  logic [2:0]  t_f3;
  logic [11:0] t_addr;
  logic [4:0]  t_rs1, t_rd;
  logic [63:0] t_data, t_old, t_wdata, t_src;
  bit          t_ill, t_do_read, t_do_write;
  logic        e_in_ready, e_rd_ena, e_wr_ena, e_valid, e_wen, e_ill;
  logic [11:0] e_rd_addr, e_wr_addr;
  logic [63:0] e_wr_data, e_rd_data;
  logic [4:0]  e_rd_idx;

  initial begin
    for (int i = 0; i < 6; i++) ref_mem[i] = INIT_VAL[i];
    ref_cnt      = CNT0 + 64'd1;  // the first posedge happens before the first model step
    ref_perf_ret = '0;
    ref_perf_ill = '0;
    busy         = 0;
    cyc          = 1;
    forever begin
      @(negedge clk);
      e_in_ready = rst && !busy;
      e_rd_ena = 0; e_rd_addr = '0; e_wr_ena = 0; e_wr_addr = '0; e_wr_data = '0;
      e_valid = 0; e_rd_idx = '0; e_wen = 0; e_rd_data = '0; e_ill = 0;
      if (busy) begin
        if (!t_ill && cyc == t_read_cyc) begin
          e_rd_ena  = t_do_read;
          e_rd_addr = t_addr;
          t_old     = !t_do_read ? 64'd0 : (t_addr == 12'hB00) ? ref_cnt : ref_mem[csr_idx(t_addr)];
          case (t_f3[1:0])
            2'b10:   t_wdata = t_old | t_src;
            2'b11:   t_wdata = t_old & ~t_src;
            default: t_wdata = t_src;
          endcase
        end
        if (!t_ill && t_do_write && cyc == t_read_cyc + 1) begin
          e_wr_ena  = 1;
          e_wr_addr = t_addr;
          e_wr_data = t_wdata;
        end
        if (cyc >= t_resp_cyc) begin
          e_valid   = 1;
          e_rd_idx  = t_rd;
          e_wen     = (t_rd != 0) && !t_ill;
          e_rd_data = t_old;
          e_ill     = t_ill;
        end
      end
      check("in_ready", in_ready, e_in_ready);
      check("csr_rd_ena", csr_rd_ena, e_rd_ena);
      check("csr_rd_addr", csr_rd_addr, e_rd_addr);
      check("csr_wr_ena", csr_wr_ena, e_wr_ena);
      check("csr_wr_addr", csr_wr_addr, e_wr_addr);
      check("csr_wr_data", csr_wr_data, e_wr_data);
      check("out_valid", out_valid, e_valid);
      check("out_rd_idx", out_rd_idx, e_rd_idx);
      check("out_rd_wen", out_rd_wen, e_wen);
      check("out_rd_data", out_rd_data, e_rd_data);
      check("out_illegal", out_illegal, e_ill);
`ifdef CSR_EXEC_PERF_EN
      check("perf_retired", perf_retired, ref_perf_ret);
      check("perf_illegal", perf_illegal, ref_perf_ill);
`endif
      // Effects of the coming posedge.
      if (e_wr_ena && e_wr_addr == 12'hB00) ref_cnt = e_wr_data;
      else begin
        if (e_wr_ena) ref_mem[csr_idx(e_wr_addr)] = e_wr_data;
        ref_cnt = ref_cnt + 64'd1;
      end
      if (!rst) begin
        busy = 0;
        ref_perf_ret = '0;
        ref_perf_ill = '0;
      end else if (busy && cyc >= t_resp_cyc && out_ready) begin
        busy = 0;
        if (t_ill) ref_perf_ill = ref_perf_ill + 32'd1;
        else       ref_perf_ret = ref_perf_ret + 64'd1;
      end else if (!busy && in_valid) begin
        busy       = 1;
        t_f3       = in_funct3;
        t_addr     = in_csr_addr;
        t_rs1      = in_rs1_idx;
        t_data     = in_rs1_data;
        t_rd       = in_rd_idx;
        t_src      = t_f3[2] ? {59'd0, t_rs1} : t_data;
        t_do_write = (t_f3[1:0] == 2'b01) || (t_rs1 != 0);
        t_do_read  = !((t_f3[1:0] == 2'b01) && (t_rd == 0));
        t_ill      = (t_f3[1:0] == 2'b00) || (t_do_write && t_addr[11:10] == 2'b11);
        t_old      = '0;
        t_wdata    = '0;
        t_read_cyc = cyc + 1;
        t_resp_cyc = cyc + 1 + (t_ill ? 0 : (t_do_write ? 2 : 1));
      end
      cyc++;
    end
  end

  // ---------------- Stimulus with hand-computed expectations ----------------
  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [63:0] d, input logic [4:0] rd);
    for (int n = 0; n < 50 && in_ready !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    check("issue_wait_in_ready", in_ready, 1'b1);
    in_valid = 1; in_funct3 = f3; in_csr_addr = a; in_rs1_idx = r1; in_rs1_data = d; in_rd_idx = rd;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic finish_resp();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    check("resp_wait_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int w_edge, rd0, wr0;
    logic [63:0] rv, exp_cnt;
    rst = 0; in_valid = 0; in_funct3 = '0; in_csr_addr = '0; in_rs1_idx = '0;
    in_rs1_data = '0; in_rd_idx = '0; out_ready = 1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // CSRRS 0x301, x0: read-only path, result two cycles after accept, no write.
    wr0 = env_wr_n;
    issue(3'b010, 12'h301, 5'd0, 64'h0, 5'd5);
    @(negedge clk);
    check("rs_x0_not_early", out_valid, 1'b0);
    @(negedge clk);
    check("rs_x0_valid", out_valid, 1'b1);
    check("rs_x0_data", out_rd_data, 64'h8000000000000100);
    check("rs_x0_wen", out_rd_wen, 1'b1);
    check("rs_x0_rd", out_rd_idx, 5'd5);
    @(posedge clk); #1;
    check("rs_x0_no_write", env_wr_n, wr0);

    // CSRRW to the counter, then read it back with CSRRS x0.
    issue(3'b001, 12'hB00, 5'd1, 64'h1234, 5'd6);
    @(negedge clk);
    rv = env_cnt;
    @(negedge clk);
    check("rw_cnt_wr_ena", csr_wr_ena, 1'b1);
    check("rw_cnt_wr_data", csr_wr_data, 64'h1234);
    w_edge = edge_n + 1;
    @(negedge clk);
    check("rw_cnt_old", out_rd_data, rv);
    @(posedge clk); #1;
    issue(3'b010, 12'hB00, 5'd0, 64'h0, 5'd7);
    @(negedge clk);
    exp_cnt = 64'h1234 + 64'(edge_n - w_edge);
    @(negedge clk);
    check("rs_cnt_readback", out_rd_data, exp_cnt);
    @(posedge clk); #1;

    // CSRRW 0x340 <- 0xFF, then CSRRCI zimm=0xF clears the low nibble.
    issue(3'b001, 12'h340, 5'd2, 64'hFF, 5'd0);
    finish_resp();
    issue(3'b111, 12'h340, 5'h0F, 64'h0, 5'd8);
    @(negedge clk);
    @(negedge clk);
    check("rci_wr_data", csr_wr_data, 64'hF0);
    @(negedge clk);
    check("rci_old", out_rd_data, 64'hFF);
    @(posedge clk); #1;

    // Illegal: write to read-only space, and funct3=100.
    rd0 = env_rd_n; wr0 = env_wr_n;
    issue(3'b001, 12'hF11, 5'd1, 64'h5, 5'd4);
    @(negedge clk);
    check("ill_ro_valid", out_valid, 1'b1);
    check("ill_ro_flag", out_illegal, 1'b1);
    check("ill_ro_wen", out_rd_wen, 1'b0);
    @(posedge clk); #1;
    issue(3'b100, 12'h340, 5'd3, 64'h5, 5'd4);
    @(negedge clk);
    check("ill_f3_flag", out_illegal, 1'b1);
    @(posedge clk); #1;
    check("ill_no_reads", env_rd_n, rd0);
    check("ill_no_writes", env_wr_n, wr0);

    // Back-pressure: RESP holds for 4 cycles.
    out_ready = 0;
    issue(3'b010, 12'h301, 5'd0, 64'h0, 5'd9);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_rd_data, 64'h8000000000000100);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    check("hs_cycle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_hs_in_ready", in_ready, 1'b1);
    check("after_hs_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset asserted during the WRITE cycle.
    issue(3'b001, 12'h340, 5'd3, 64'hABCD, 5'd3);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rstw_in_write", csr_wr_ena, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rstw_outputs_zero", {csr_rd_ena, csr_rd_addr, csr_wr_ena, csr_wr_addr, out_valid,
                                out_rd_idx, out_rd_wen, out_illegal}, 64'd0);
    check("rstw_data_zero", csr_wr_data | out_rd_data, 64'd0);
    check("rstw_in_ready", in_ready, 1'b1);
`ifdef CSR_EXEC_PERF_EN
    check("rstw_perf_ret", perf_retired, 64'd0);
    check("rstw_perf_ill", perf_illegal, 64'd0);
`endif
    @(posedge clk); #1;

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      in_valid    = ($urandom_range(0, 1) == 1);
      in_funct3   = 3'($urandom_range(0, 7));
      in_csr_addr = ADDRS[$urandom_range(0, 5)];
      in_rs1_idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_rs1_data = {$urandom, $urandom};
      in_rd_idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
